// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and constants for the pipeline sequencing logic
package pipeline_pkg;

  // Sequencer states: normal flow, or EX held by a multi-cycle mul/div
  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_e;

  // Architectural zero register; writes to it never create a dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Control bundle carried by latch_id_ex; NOP is the all-zero bubble
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic [1:0] alu_op;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t NOP = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// rtl/pipeline_hazard_ctrl_hazard_detect.sv - combinational load-use dependency compare
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic       ex_mem_to_reg,
  input  logic [4:0] ex_wr_reg,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  output logic       load_use
);

  // A load in EX feeds a register the ID instruction actually reads; $0 never counts
  always_comb begin
    load_use = ex_mem_to_reg && (ex_wr_reg != REG_ZERO) &&
               ((id_use_rs && (id_rs == ex_wr_reg)) ||
                (id_use_rt && (id_rt == ex_wr_reg)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the IF/ID and ID/EX registers
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_stall,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_muldiv,
  input  logic             ex_mem_to_reg,
  input  logic [4:0]       ex_wr_reg,
  input  logic             ex_branch_taken,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0] MD_INIT = 4'(MULDIV_LAT - 1);

  state_e             state_q, state_d;
  logic [3:0]         md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               load_use;

  hazard_detect u_hazard_detect (
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_wr_reg     (ex_wr_reg),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_use_rs     (id_use_rs),
    .id_use_rt     (id_use_rt),
    .load_use      (load_use)
  );

  // Pipeline controls and next state; reset low forces every control inactive
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b0;
    id_ex_flush = 1'b0;
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    if (rst) begin
      unique case (state_q)
        RUN: begin
          if (ext_stall) begin
            // whole front end frozen
          end else if (ex_branch_taken) begin
            // the branch kills both younger instructions, including any mul/div in ID
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            // hold IF/ID and PC, push one bubble into EX
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
          end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
            id_ex_en = 1'b1;
            if (id_muldiv) begin
              state_d  = MD_BUSY;
              md_cnt_d = MD_INIT;
            end
          end
        end
        MD_BUSY: begin
          if (!ext_stall) begin
            md_cnt_d = md_cnt_q - 4'd1;
            if (md_cnt_q == 4'd1) begin
              state_d = RUN;
            end
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Stall counter sticks at all-ones so long runs stay visibly pegged
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Sequencer state, mul/div occupancy counter and stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy      = rst && (state_q == MD_BUSY);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        ext_stall;
  logic [4:0]  id_rs, id_rt;
  logic        id_use_rs, id_use_rt;
  logic        id_muldiv;
  logic        ex_mem_to_reg;
  logic [4:0]  ex_wr_reg;
  logic        ex_branch_taken;

  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, busy;
  logic [15:0] stall_cnt;

  logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_flush, s_busy;
  logic [3:0]  s_stall_cnt;

  int tests_run;
  int tests_failed;

  pipeline_hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(16)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .ext_stall       (ext_stall),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_muldiv       (id_muldiv),
    .ex_mem_to_reg   (ex_mem_to_reg),
    .ex_wr_reg       (ex_wr_reg),
    .ex_branch_taken (ex_branch_taken),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .if_id_flush     (if_id_flush),
    .id_ex_en        (id_ex_en),
    .id_ex_flush     (id_ex_flush),
    .busy            (busy),
    .stall_cnt       (stall_cnt)
  );

  pipeline_hazard_ctrl #(.MULDIV_LAT(2), .CNT_W(4)) u_sat (
    .clk             (clk),
    .rst             (rst),
    .ext_stall       (ext_stall),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_muldiv       (id_muldiv),
    .ex_mem_to_reg   (ex_mem_to_reg),
    .ex_wr_reg       (ex_wr_reg),
    .ex_branch_taken (ex_branch_taken),
    .pc_en           (s_pc_en),
    .if_id_en        (s_if_id_en),
    .if_id_flush     (s_if_id_flush),
    .id_ex_en        (s_id_ex_en),
    .id_ex_flush     (s_id_ex_flush),
    .busy            (s_busy),
    .stall_cnt       (s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ext_stall       = 1'b0;
    id_rs           = 5'd0;
    id_rt           = 5'd0;
    id_use_rs       = 1'b0;
    id_use_rt       = 1'b0;
    id_muldiv       = 1'b0;
    ex_mem_to_reg   = 1'b0;
    ex_wr_reg       = 5'd0;
    ex_branch_taken = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    clear_inputs();

    // reset state
    #2;
    chk("rst_pc_en", 32'(pc_en), 0);
    chk("rst_if_id_en", 32'(if_id_en), 0);
    chk("rst_id_ex_en", 32'(id_ex_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);

    @(negedge clk); rst = 1'b1;
    #1;
    chk("idle_pc_en", 32'(pc_en), 1);
    chk("idle_id_ex_flush", 32'(id_ex_flush), 0);

    // load-use through rs
    @(negedge clk);
    ex_mem_to_reg = 1'b1; ex_wr_reg = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    #1;
    chk("lu_pc_en", 32'(pc_en), 0);
    chk("lu_if_id_en", 32'(if_id_en), 0);
    chk("lu_id_ex_en", 32'(id_ex_en), 1);
    chk("lu_id_ex_flush", 32'(id_ex_flush), 1);
    chk("lu_if_id_flush", 32'(if_id_flush), 0);
    @(negedge clk); clear_inputs();
    #1;
    chk("lu_after_pc_en", 32'(pc_en), 1);
    chk("lu_after_if_id_en", 32'(if_id_en), 1);
    chk("lu_after_flush", 32'(id_ex_flush), 0);
    chk("lu_stall_cnt", 32'(stall_cnt), 1);

    // load to $0 is not a hazard
    @(negedge clk);
    ex_mem_to_reg = 1'b1; ex_wr_reg = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    #1;
    chk("r0_pc_en", 32'(pc_en), 1);
    // rt matches but is not read
    @(negedge clk);
    clear_inputs();
    ex_mem_to_reg = 1'b1; ex_wr_reg = 5'd7; id_rt = 5'd7; id_use_rt = 1'b0;
    #1;
    chk("rt_unused_pc_en", 32'(pc_en), 1);
    // same compare with rt read does stall
    @(negedge clk); id_use_rt = 1'b1;
    #1;
    chk("rt_used_pc_en", 32'(pc_en), 0);
    chk("rt_used_flush", 32'(id_ex_flush), 1);
    @(negedge clk); clear_inputs();
    #1;
    chk("rt_stall_cnt", 32'(stall_cnt), 2);

    // branch outranks load-use
    @(negedge clk);
    ex_mem_to_reg = 1'b1; ex_wr_reg = 5'd9; id_rs = 5'd9; id_use_rs = 1'b1;
    ex_branch_taken = 1'b1;
    #1;
    chk("br_pc_en", 32'(pc_en), 1);
    chk("br_if_id_en", 32'(if_id_en), 1);
    chk("br_id_ex_en", 32'(id_ex_en), 1);
    chk("br_if_id_flush", 32'(if_id_flush), 1);
    chk("br_id_ex_flush", 32'(id_ex_flush), 1);
    @(negedge clk); clear_inputs();
    #1;
    chk("br_stall_cnt", 32'(stall_cnt), 2);

    // mul/div, 3 busy cycles; branch/load-use ignored while busy
    @(negedge clk); id_muldiv = 1'b1;
    #1;
    chk("md_issue_pc_en", 32'(pc_en), 1);
    chk("md_issue_busy", 32'(busy), 0);
    chk("md_issue_flush", 32'(id_ex_flush), 0);
    @(negedge clk); clear_inputs();
    #1;
    chk("md_b1_busy", 32'(busy), 1);
    chk("md_b1_pc_en", 32'(pc_en), 0);
    chk("md_b1_if_id_en", 32'(if_id_en), 0);
    chk("md_b1_id_ex_en", 32'(id_ex_en), 0);
    chk("md2_b1_busy", 32'(s_busy), 1);
    @(negedge clk);
    ex_branch_taken = 1'b1;
    ex_mem_to_reg = 1'b1; ex_wr_reg = 5'd3; id_rs = 5'd3; id_use_rs = 1'b1;
    #1;
    chk("md_b2_busy", 32'(busy), 1);
    chk("md_b2_pc_en", 32'(pc_en), 0);
    chk("md_b2_if_id_flush", 32'(if_id_flush), 0);
    chk("md_b2_id_ex_flush", 32'(id_ex_flush), 0);
    chk("md2_b2_busy", 32'(s_busy), 0);
    @(negedge clk); clear_inputs();
    #1;
    chk("md_b3_busy", 32'(busy), 1);
    @(negedge clk);
    #1;
    chk("md_done_busy", 32'(busy), 0);
    chk("md_done_pc_en", 32'(pc_en), 1);
    chk("md_stall_cnt", 32'(stall_cnt), 5);

    // mul/div stretched by two ext_stall cycles
    @(negedge clk); id_muldiv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      clear_inputs();
      ext_stall = (i == 1) || (i == 2);
      #1;
      chk($sformatf("mdx_b%0d_busy", i + 1), 32'(busy), 1);
      chk($sformatf("mdx_b%0d_pc_en", i + 1), 32'(pc_en), 0);
    end
    @(negedge clk); clear_inputs();
    #1;
    chk("mdx_done_busy", 32'(busy), 0);
    chk("mdx_stall_cnt", 32'(stall_cnt), 10);

    // asynchronous reset during the 2nd busy cycle
    @(negedge clk); id_muldiv = 1'b1;
    @(negedge clk); clear_inputs();
    #1;
    chk("rmd_b1_busy", 32'(busy), 1);
    @(negedge clk);
    #2; rst = 1'b0;
    #1;
    chk("rmd_busy", 32'(busy), 0);
    chk("rmd_pc_en", 32'(pc_en), 0);
    chk("rmd_if_id_en", 32'(if_id_en), 0);
    chk("rmd_id_ex_en", 32'(id_ex_en), 0);
    chk("rmd_stall_cnt", 32'(stall_cnt), 0);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rmd_rel_pc_en", 32'(pc_en), 1);
    chk("rmd_rel_busy", 32'(busy), 0);
    @(negedge clk);
    #1;
    chk("rmd_rel_stall_cnt", 32'(stall_cnt), 0);
    chk("rmd_rel_busy2", 32'(busy), 0);

    // ext_stall outranks branch, and saturation of a 4-bit counter
    @(negedge clk); ext_stall = 1'b1; ex_branch_taken = 1'b1;
    #1;
    chk("xs_pc_en", 32'(pc_en), 0);
    chk("xs_id_ex_en", 32'(id_ex_en), 0);
    chk("xs_if_id_flush", 32'(if_id_flush), 0);
    chk("xs_id_ex_flush", 32'(id_ex_flush), 0);
    repeat (20) @(negedge clk);
    #1;
    chk("sat_stall_cnt", 32'(s_stall_cnt), 15);
    chk("wide_stall_cnt", 32'(stall_cnt), 20);
    repeat (3) @(negedge clk);
    #1;
    chk("sat_hold_stall_cnt", 32'(s_stall_cnt), 15);
    chk("wide_hold_stall_cnt", 32'(stall_cnt), 23);
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
